// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract engine. A single 1-bit full-adder slice is run
//   over WIDTH cycles, LSB first, to produce a WIDTH-bit sum or difference
//   plus carry, signed-overflow and zero flags. Intended for ALU paths where
//   a multi-cycle result is acceptable in exchange for a very small adder.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request, sampled only in IDLE or DONE
//   op        in   1      0 = ADD (a+b), 1 = SUB (a-b); sampled with start
//   a, b      in   WIDTH  operands; sampled with start
//   busy      out  1      high for the WIDTH cycles of a calculation
//   done      out  1      one-cycle pulse; result/flags valid from this cycle
//   result    out  WIDTH  sum/difference, held until the next done
//   cout      out  1      ADD: carry out; SUB: no-borrow (a >= b unsigned)
//   overflow  out  1      signed two's-complement overflow
//   zero      out  1      result == 0
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;

  logic [1:0]       slice;     // {carry_out, sum}
  logic [WIDTH-1:0] sum_next;
  logic             last_bit;

  // One full-adder slice; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  always_comb begin
    slice    = full_add(op_a[0], op_b[0], carry);
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    sum_next = {slice[0], sum_sr[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // SUB is a + ~b + 1: invert b and seed the carry with 1.
            state <= S_RUN;
            busy  <= 1'b1;
            op_a  <= a;
            op_b  <= op ? ~b : b;
            carry <= op;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          sum_sr <= sum_next;
          carry  <= slice[1];
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the final bit 'carry' is the carry into the MSB, so
            // overflow is simply carry-in(MSB) xor carry-out(MSB).
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= sum_next;
            cout     <= slice[1];
            overflow <= carry ^ slice[1];
            zero     <= (sum_next == '0);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
